// File: rtl/pbit_update_engine.sv
// Sequential p-bit update engine: one p-bit per run cycle, stochastic sign from a 16-bit Galois LFSR.
// Optional per-p-bit clamping when PBIT_CLAMP_EN is defined.
module pbit_update_engine #(
  parameter int unsigned N    = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [4*N-1:0]       act_in,
`ifdef PBIT_CLAMP_EN
  input  logic [N-1:0]         clamp_mask,
  input  logic [N-1:0]         clamp_val,
`endif
  output logic [N-1:0]         state_out,
  output logic [$clog2(N)-1:0] upd_idx,
  output logic                 sweep_done,
  output logic [15:0]          sweep_cnt
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  // An all-zero Galois LFSR would lock up, so fall back to the default seed.
  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] PolyMask = 16'hB400;

  logic [N-1:0]    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            done_q, done_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [3:0]      act_sel;
  logic [3:0]      rnd;
  logic [4:0]      sum;
  logic            new_bit;

  assign act_sel = act_in[{idx_q, 2'b00} +: 4];
  assign rnd     = lfsr_q[3:0];
  assign sum     = {act_sel[3], act_sel} + {rnd[3], rnd};

  always_comb begin
    new_bit = ~sum[4];
`ifdef PBIT_CLAMP_EN
    if (clamp_mask[idx_q]) new_bit = clamp_val[idx_q];
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (run) begin
      state_d[idx_q] = new_bit;
      lfsr_d         = (lfsr_q >> 1) ^ (lfsr_q[0] ? PolyMask : 16'h0000);
      if (idx_q == LastIdx) begin
        idx_d  = '0;
        done_d = 1'b1;
        cnt_d  = cnt_q + 16'd1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      idx_q   <= '0;
      lfsr_q  <= SeedEff;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_out  = state_q;
  assign upd_idx    = idx_q;
  assign sweep_done = done_q;
  assign sweep_cnt  = cnt_q;

endmodule

// File: tb/tb_pbit_update_engine.sv
// Directed self-checking bench for pbit_update_engine (N=4, default seed).
module tb_pbit_update_engine;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [4*N-1:0] act_in;
`ifdef PBIT_CLAMP_EN
  logic [N-1:0]  clamp_mask;
  logic [N-1:0]  clamp_val;
`endif
  logic [N-1:0]  state_out;
  logic [1:0]    upd_idx;
  logic          sweep_done;
  logic [15:0]   sweep_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0]  lfsr_m;
  logic [N-1:0] state_m;
  int           idx_m;
  logic         done_m;
  int           cnt_m;

  always #5 clk = ~clk;

  pbit_update_engine #(.N(N), .SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .act_in     (act_in),
`ifdef PBIT_CLAMP_EN
    .clamp_mask (clamp_mask),
    .clamp_val  (clamp_val),
`endif
    .state_out  (state_out),
    .upd_idx    (upd_idx),
    .sweep_done (sweep_done),
    .sweep_cnt  (sweep_cnt)
  );

  // Advance the model with the currently driven inputs, then take one DUT edge.
  task automatic tick();
    logic [3:0] a;
    logic [3:0] r;
    int ai, ri;
    if (rst) begin
      lfsr_m = 16'hACE1; state_m = '0; idx_m = 0; done_m = 1'b0; cnt_m = 0;
    end else if (run) begin
      a  = act_in[idx_m*4 +: 4];
      r  = lfsr_m[3:0];
      ai = $signed(a);
      ri = $signed(r);
      state_m[idx_m] = (ai + ri >= 0);
`ifdef PBIT_CLAMP_EN
      if (clamp_mask[idx_m]) state_m[idx_m] = clamp_val[idx_m];
`endif
      done_m = (idx_m == N - 1);
      if (done_m) cnt_m = (cnt_m + 1) % 65536;
      idx_m  = (idx_m + 1) % N;
      lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end else begin
      done_m = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    run = 1'b1;
    act_in = {N{4'sd7}};
    do_reset();
    n_checks++;
    if (state_out !== 4'b0000) begin n_fail++; $display("FAIL reset_state: got %b want 0000", state_out); end
    n_checks++;
    if (upd_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", upd_idx); end
    n_checks++;
    if (sweep_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", sweep_cnt); end
    n_checks++;
    if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", sweep_done); end
  endtask

  task automatic test_all_neg();
    int bad_state = 0;
    int bad_done  = 0;
    run = 1'b0;
    act_in = {N{4'b1000}};
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (state_out !== 4'b0000) bad_state++;
      if (sweep_done !== ((k % 4) == 0)) bad_done++;
    end
    run = 1'b0;
    n_checks++;
    if (bad_state != 0) begin n_fail++; $display("FAIL neg_state: %0d cycles nonzero, want 0", bad_state); end
    n_checks++;
    if (bad_done != 0) begin n_fail++; $display("FAIL neg_done_pulses: %0d cycles wrong, want 0", bad_done); end
    n_checks++;
    if (sweep_cnt !== 16'd10) begin n_fail++; $display("FAIL neg_cnt: got %0d want 10", sweep_cnt); end
    tick();
    n_checks++;
    if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL neg_done_idle: got %b want 0", sweep_done); end
  endtask

  task automatic test_all_pos();
    int bad = 0;
    run = 1'b0;
    act_in = {N{4'sd7}};
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      // Seed ACE1 yields r = 1, 0, -8, -4: third update lands on 0.
      if (k == 3) begin
        n_checks++;
        if (state_out !== 4'b0011) begin n_fail++; $display("FAIL pos_hand3: got %b want 0011", state_out); end
      end
      if (k == 4) begin
        n_checks++;
        if (state_out !== 4'b1011) begin n_fail++; $display("FAIL pos_hand4: got %b want 1011", state_out); end
      end
      if (state_out !== state_m) bad++;
    end
    run = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL pos_model: %0d cycles differ, want 0", bad); end
  endtask

  task automatic test_run_gating();
    int exp_idx [9] = '{1, 2, 2, 2, 2, 2, 2, 3, 0};
    logic [8:0] run_pat = 9'b110000011;
    int bad = 0;
    run = 1'b0;
    act_in = '0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      run = run_pat[8 - k];
      tick();
      if (upd_idx !== 2'(exp_idx[k])) bad++;
    end
    run = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL gate_idx: %0d cycles wrong, want 0", bad); end
    // Frozen LFSR during the gap keeps r = -8, -4 for indices 2,3.
    n_checks++;
    if (state_out !== 4'b0011) begin n_fail++; $display("FAIL gate_lfsr: got %b want 0011", state_out); end
    n_checks++;
    if (sweep_cnt !== 16'd1) begin n_fail++; $display("FAIL gate_cnt: got %0d want 1", sweep_cnt); end
  endtask

  task automatic test_act_change();
    int bad = 0;
    run = 1'b0;
    do_reset();
    run = 1'b1;
    // Only the selected index sees -8; all others see 7 and must not matter.
    for (int k = 0; k < 8; k++) begin
      act_in = {N{4'sd7}};
      act_in[idx_m*4 +: 4] = 4'b1000;
      tick();
    end
    n_checks++;
    if (state_out !== 4'b0000) begin n_fail++; $display("FAIL nonsel_neg: got %b want 0000", state_out); end
    for (int k = 0; k < 12; k++) begin
      act_in = {N{4'b1000}};
      act_in[idx_m*4 +: 4] = 4'sd7;
      tick();
      if (state_out !== state_m) bad++;
    end
    run = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL nonsel_pos: %0d cycles differ, want 0", bad); end
  endtask

  task automatic test_fraction();
    int ones = 0;
    int bad  = 0;
    int prev;
    run = 1'b0;
    act_in = '0;
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 16000; k++) begin
      prev = idx_m;
      tick();
      if (state_out[prev] === 1'b1) ones++;
      if (state_out !== state_m) bad++;
    end
    run = 1'b0;
    n_checks++;
    if (ones < 7680 || ones > 8320) begin
      n_fail++; $display("FAIL frac_ones: got %0d want 7680..8320", ones);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL frac_model: %0d cycles differ, want 0", bad); end
    n_checks++;
    if (sweep_cnt !== 16'd4000) begin n_fail++; $display("FAIL frac_cnt: got %0d want 4000", sweep_cnt); end
  endtask

  task automatic test_reset_mid_sweep();
    run = 1'b0;
    act_in = {N{4'sd7}};
    do_reset();
    run = 1'b1;
    tick();
    tick();
    n_checks++;
    if (upd_idx !== 2'd2) begin n_fail++; $display("FAIL mid_pre_idx: got %0d want 2", upd_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (upd_idx !== 2'd0 || sweep_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: got idx %0d done %b want idx 0 done 0", upd_idx, sweep_done);
    end
    // act=-1 with r = SEED[3:0] = 1 gives sum 0 -> +1.
    act_in = {N{4'b1111}};
    tick();
    n_checks++;
    if (state_out !== 4'b0001 || upd_idx !== 2'd1 || sweep_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_first: got state %b idx %0d done %b want 0001 1 0", state_out, upd_idx, sweep_done);
    end
    run = 1'b0;
  endtask

`ifdef PBIT_CLAMP_EN
  task automatic test_clamp();
    clamp_mask = 4'b0101;
    clamp_val  = 4'b0001;
    run = 1'b0;
    act_in = {N{4'b1000}};
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    run = 1'b0;
    n_checks++;
    if (state_out !== 4'b0001) begin n_fail++; $display("FAIL clamp_state: got %b want 0001", state_out); end
    clamp_mask = '0;
  endtask
`endif

  initial begin
    rst = 1'b0;
    run = 1'b0;
    act_in = '0;
`ifdef PBIT_CLAMP_EN
    clamp_mask = '0;
    clamp_val  = '0;
`endif
    lfsr_m = 16'hACE1; state_m = '0; idx_m = 0; done_m = 1'b0; cnt_m = 0;
    test_reset();
    test_all_neg();
    test_all_pos();
    test_run_gating();
    test_act_change();
    test_reset_mid_sweep();
`ifdef PBIT_CLAMP_EN
    test_clamp();
`endif
    test_fraction();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
